fifo_access_sched: RTL

Access scheduler for the shared 16-bit byte-packed FIFO. It arbitrates up to NUM_WR write requesters and one read requester onto the FIFO's single wr_en/rd_en/data_in port set. It guarantees that wr_en and rd_en are never asserted in the same cycle, and it keeps an exact word-occupancy count, so requesters never depend on the FIFO's registered full/empty flags, which lag by one cycle. It sits directly in front of the FIFO instance and owns every access to it.

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 41 ++++
 rtl/fifo_access_sched.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared widths and scheduler enums for the byte-packed FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int DATA_W      = 16;
    localparam int DEPTH_WORDS = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_BURST = 2'd2
    } sched_state_t;

    typedef enum logic {
        RD = 1'b0,
        WR = 1'b1
    } dir_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick, searching from ptr+1 upward.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
#(
    parameter int NUM_WR = 3,
    parameter int ID_W   = (NUM_WR > 1) ? $clog2(NUM_WR) : 1
) (
    input  logic [NUM_WR-1:0] req,
    input  logic [ID_W-1:0]   ptr,
    output logic [NUM_WR-1:0] gnt,
    output logic [ID_W-1:0]   idx,
    output logic              any
);
    import fifo_pkg::*;

    logic [ID_W-1:0] w_cand;
    logic            w_found;

    assign any = |req;

    always_comb begin
        gnt     = '0;
        idx     = '0;
        w_cand  = '0;
        w_found = 1'b0;
        for (int i = 1; i <= NUM_WR; i++) begin
            w_cand = ID_W'((int'(ptr) + i) % NUM_WR);
            if (!w_found && req[w_cand]) begin
                w_found     = 1'b1;
                gnt[w_cand] = 1'b1;
                idx         = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_access_sched.sv
`default_nettype none
// ============================================================================
// Module      : fifo_access_sched
// Description : Burst-limited write/read scheduler with exact FIFO occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_access_sched
#(
    parameter int NUM_WR      = 3,
    parameter int DATA_W      = fifo_pkg::DATA_W,
    parameter int DEPTH_WORDS = fifo_pkg::DEPTH_WORDS,
    parameter int MAX_BURST   = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_WR-1:0]                wr_req,
    input  logic [NUM_WR*DATA_W-1:0]         wr_data,
    output logic [NUM_WR-1:0]                wr_ack,
    input  logic                             rd_req,
    output logic                             rd_ack,
    output logic [DATA_W-1:0]                rd_data,
    output logic                             rd_data_vld,
    output logic                             fifo_wr_en,
    output logic                             fifo_rd_en,
    output logic [DATA_W-1:0]                fifo_data_in,
    input  logic [DATA_W-1:0]                fifo_data_out,
    output logic [$clog2(DEPTH_WORDS+1)-1:0] occupancy,
    output logic                             full,
    output logic                             empty,
    output logic [$clog2(NUM_WR)-1:0]        grant_id
);
    import fifo_pkg::*;

    localparam int ID_W   = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;
    localparam int OCC_W  = $clog2(DEPTH_WORDS + 1);
    localparam int BEAT_W = $clog2(MAX_BURST + 1);

    sched_state_t      r_state, w_state_nxt;
    dir_t              r_last_dir, w_last_dir_nxt;
    logic [OCC_W-1:0]  r_occ;
    logic [BEAT_W-1:0] r_beats, w_beats_nxt, w_beat_inc;
    logic [ID_W-1:0]   r_rr_ptr, r_grant_id;
    logic              r_rd_vld;

    logic [NUM_WR-1:0] w_arb_gnt, w_ack_vec;
    logic [ID_W-1:0]   w_arb_idx, w_sel;
    logic              w_arb_any, w_wr_ok, w_rd_ok, w_full, w_empty;
    logic              w_do_wr, w_do_rd, w_take_grant;
    logic [DATA_W-1:0] w_wr_words [NUM_WR];

    generate
        for (genvar g = 0; g < NUM_WR; g++) begin : g_unpack
            assign w_wr_words[g] = wr_data[g*DATA_W +: DATA_W];
        end
    endgenerate

    rr_arbiter #(.NUM_WR(NUM_WR), .ID_W(ID_W)) u_arb (
        .req (wr_req),
        .ptr (r_rr_ptr),
        .gnt (w_arb_gnt),
        .idx (w_arb_idx),
        .any (w_arb_any)
    );

    assign w_full     = (r_occ == OCC_W'(DEPTH_WORDS));
    assign w_empty    = (r_occ == '0);
    assign w_wr_ok    = w_arb_any && !w_full;
    assign w_rd_ok    = rd_req && !w_empty;
    assign w_beat_inc = r_beats + 1'b1;

    // Nothing is issued while rst is high, so the reset edge never races a transfer.
    always_comb begin
        w_state_nxt    = r_state;
        w_beats_nxt    = r_beats;
        w_last_dir_nxt = r_last_dir;
        w_do_wr        = 1'b0;
        w_do_rd        = 1'b0;
        w_take_grant   = 1'b0;
        w_ack_vec      = '0;
        if (!rst) begin
            unique case (r_state)
                IDLE: begin
                    if (w_wr_ok && (!w_rd_ok || r_last_dir == RD)) begin
                        w_do_wr        = 1'b1;
                        w_take_grant   = 1'b1;
                        w_ack_vec      = w_arb_gnt;
                        w_beats_nxt    = BEAT_W'(1);
                        w_state_nxt    = (MAX_BURST == 1) ? IDLE : WR_BURST;
                        w_last_dir_nxt = WR;
                    end else if (w_rd_ok) begin
                        w_do_rd        = 1'b1;
                        w_beats_nxt    = BEAT_W'(1);
                        w_state_nxt    = (MAX_BURST == 1) ? IDLE : RD_BURST;
                        w_last_dir_nxt = RD;
                    end
                end
                WR_BURST: begin
                    if (wr_req[r_grant_id] && !w_full) begin
                        w_do_wr               = 1'b1;
                        w_ack_vec[r_grant_id] = 1'b1;
                        w_beats_nxt           = w_beat_inc;
                        if (w_beat_inc == BEAT_W'(MAX_BURST)) w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
                RD_BURST: begin
                    if (rd_req && !w_empty) begin
                        w_do_rd     = 1'b1;
                        w_beats_nxt = w_beat_inc;
                        if (w_beat_inc == BEAT_W'(MAX_BURST)) w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_occ      <= '0;
            r_beats    <= '0;
            r_rr_ptr   <= ID_W'(NUM_WR - 1);
            r_last_dir <= RD;
            r_grant_id <= '0;
            r_rd_vld   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_beats    <= w_beats_nxt;
            r_last_dir <= w_last_dir_nxt;
            r_rd_vld   <= w_do_rd;
            if (w_take_grant) begin
                r_rr_ptr   <= w_arb_idx;
                r_grant_id <= w_arb_idx;
            end
            if (w_do_wr)      r_occ <= r_occ + 1'b1;
            else if (w_do_rd) r_occ <= r_occ - 1'b1;
        end
    end

    assign w_sel        = w_take_grant ? w_arb_idx : r_grant_id;
    assign wr_ack       = w_ack_vec;
    assign fifo_wr_en   = w_do_wr;
    assign fifo_data_in = w_wr_words[w_sel];
    assign rd_ack       = w_do_rd;
    assign fifo_rd_en   = w_do_rd;
    assign rd_data      = fifo_data_out;
    assign rd_data_vld  = r_rd_vld;
    assign occupancy    = r_occ;
    assign full         = w_full;
    assign empty        = w_empty;
    assign grant_id     = r_grant_id;

endmodule
`default_nettype wire
